// File: rtl/sdram_arbiter.sv
// SDRAM command sequencer: runs power-up init, then time-shares the
// command bus between refresh, write and read engines.
module sdram_arbiter #(
   parameter int REF_PERIOD = 780
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        init_en,
   input  logic        init_done,
   input  logic [19:0] init_bus,
   output logic        ref_en,
   output logic        wr_en,
   output logic        rd_en,
   input  logic        ref_done,
   input  logic        wr_done,
   input  logic        rd_done,
   input  logic [19:0] ref_bus,
   input  logic [19:0] wr_bus,
   input  logic [19:0] rd_bus,
   input  logic        wr_req,
   input  logic        rd_req,
   output logic        ref_req,
   output logic        ref_overrun,
   output logic        busy,
   output logic        sdram_cke,
   output logic        sdram_cs_n,
   output logic        sdram_ras_n,
   output logic        sdram_cas_n,
   output logic        sdram_we_n,
   output logic [12:0] sdram_addr,
   output logic [1:0]  sdram_ba
);

   localparam logic [2:0] S_INIT  = 3'd0;
   localparam logic [2:0] S_ARBIT = 3'd1;
   localparam logic [2:0] S_AREF  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_READ  = 3'd4;

   localparam logic [19:0] BUS_NOP = {4'b0111, 1'b1, 13'd0, 2'd0};
   localparam logic [19:0] BUS_RST = {4'b1111, 1'b0, 13'd0, 2'd0};
   localparam logic [15:0] TC      = 16'(REF_PERIOD - 1);

   logic [2:0]  state_q, state_d;
   logic        init_en_q, init_en_d;
   logic        ref_en_q, ref_en_d;
   logic        wr_en_q, wr_en_d;
   logic        rd_en_q, rd_en_d;
   logic        last_wr_q, last_wr_d;
   logic        ref_req_q, ref_req_d;
   logic        ovr_q, ovr_d;
   logic        tmr_on_q, tmr_on_d;
   logic [15:0] cnt_q, cnt_d;
   logic        tc;
   logic        enter_aref;
   logic [19:0] bus;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_INIT: begin
            if (init_done) state_d = S_ARBIT;
         end
         S_ARBIT: begin
            if (ref_req_q)            state_d = S_AREF;
            else if (wr_req && rd_req) state_d = last_wr_q ? S_READ : S_WRITE;
            else if (wr_req)          state_d = S_WRITE;
            else if (rd_req)          state_d = S_READ;
         end
         S_AREF: begin
            if (ref_done) state_d = S_ARBIT;
         end
         S_WRITE: begin
            if (wr_done) state_d = S_ARBIT;
         end
         S_READ: begin
            if (rd_done) state_d = S_ARBIT;
         end
         default: state_d = S_INIT;
      endcase
   end

   always_comb begin
      init_en_d = (state_d == S_INIT);
      ref_en_d  = (state_d == S_AREF);
      wr_en_d   = (state_d == S_WRITE);
      rd_en_d   = (state_d == S_READ);
      last_wr_d = last_wr_q;
      if (state_q == S_ARBIT && state_d == S_WRITE) last_wr_d = 1'b1;
      if (state_q == S_ARBIT && state_d == S_READ)  last_wr_d = 1'b0;
   end

   // Timer is armed one cycle after leaving INIT so the first request
   // lands REF_PERIOD+1 edges after the init_done edge.
   always_comb begin
      tmr_on_d = (state_q != S_INIT);
      tc       = tmr_on_q && (cnt_q == TC);
      if (state_q == S_INIT || !tmr_on_q) cnt_d = 16'd0;
      else if (tc)                        cnt_d = 16'd0;
      else                                cnt_d = cnt_q + 16'd1;
   end

   always_comb begin
      enter_aref = (state_q == S_ARBIT) && (state_d == S_AREF);
      ref_req_d  = ref_req_q;
      if (enter_aref) ref_req_d = 1'b0;
      if (tc)         ref_req_d = 1'b1;
      ovr_d = ovr_q | (tc & ref_req_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_INIT;
         init_en_q <= 1'b0;
         ref_en_q  <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         last_wr_q <= 1'b0;
         ref_req_q <= 1'b0;
         ovr_q     <= 1'b0;
         tmr_on_q  <= 1'b0;
         cnt_q     <= 16'd0;
      end else begin
         state_q   <= state_d;
         init_en_q <= init_en_d;
         ref_en_q  <= ref_en_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         last_wr_q <= last_wr_d;
         ref_req_q <= ref_req_d;
         ovr_q     <= ovr_d;
         tmr_on_q  <= tmr_on_d;
         cnt_q     <= cnt_d;
      end
   end

   // Pins are inhibited with cke low for as long as reset is held.
   always_comb begin
      bus = BUS_NOP;
      unique case (state_q)
         S_INIT:  bus = init_bus;
         S_ARBIT: bus = BUS_NOP;
         S_AREF:  bus = ref_bus;
         S_WRITE: bus = wr_bus;
         S_READ:  bus = rd_bus;
         default: bus = BUS_NOP;
      endcase
      if (!rst_n) bus = BUS_RST;
   end

   assign sdram_cs_n  = bus[19];
   assign sdram_ras_n = bus[18];
   assign sdram_cas_n = bus[17];
   assign sdram_we_n  = bus[16];
   assign sdram_cke   = bus[15];
   assign sdram_addr  = bus[14:2];
   assign sdram_ba    = bus[1:0];

   assign init_en     = init_en_q;
   assign ref_en      = ref_en_q;
   assign wr_en       = wr_en_q;
   assign rd_en       = rd_en_q;
   assign ref_req     = ref_req_q;
   assign ref_overrun = ovr_q;
   assign busy        = (state_q != S_ARBIT);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: init, refresh cadence, alternation,
// refresh-after-write, overrun and asynchronous reset.
module tb_sdram_arbiter;

   localparam int P = 100;

   localparam logic [19:0] INIT_B = 20'h5A3C1;
   localparam logic [19:0] REF_B  = 20'h18004;
   localparam logic [19:0] WR_B   = 20'h48ABC;
   localparam logic [19:0] RD_B   = 20'h58DEF;
   localparam logic [19:0] NOP_B  = 20'h78000;
   localparam logic [19:0] RST_B  = 20'hF0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        init_en, ref_en, wr_en, rd_en;
   logic        init_done = 1'b0;
   logic        ref_done = 1'b0, wr_done = 1'b0, rd_done = 1'b0;
   logic        wr_req = 1'b0, rd_req = 1'b0;
   logic        ref_req, ref_overrun, busy;
   logic        cke, cs_n, ras_n, cas_n, we_n;
   logic [12:0] addr;
   logic [1:0]  ba;
   logic [19:0] pins;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int e0 = 0;
   int hi_cnt = 0;

   sdram_arbiter #(.REF_PERIOD(P)) dut (
      .clk(clk), .rst_n(rst_n),
      .init_en(init_en), .init_done(init_done), .init_bus(INIT_B),
      .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
      .ref_done(ref_done), .wr_done(wr_done), .rd_done(rd_done),
      .ref_bus(REF_B), .wr_bus(WR_B), .rd_bus(RD_B),
      .wr_req(wr_req), .rd_req(rd_req),
      .ref_req(ref_req), .ref_overrun(ref_overrun), .busy(busy),
      .sdram_cke(cke), .sdram_cs_n(cs_n), .sdram_ras_n(ras_n),
      .sdram_cas_n(cas_n), .sdram_we_n(we_n),
      .sdram_addr(addr), .sdram_ba(ba)
   );

   assign pins = {cs_n, ras_n, cas_n, we_n, cke, addr, ba};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Park on the falling edge after edge e0+n.
   task automatic to_edge(input int n);
      while (cyc - e0 < n) @(negedge clk);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      chk("rst_pins", 32'(pins), 32'(RST_B));
      chk("rst_init_en", 32'(init_en), 0);
      chk("rst_busy", 32'(busy), 1);
      chk("rst_req", 32'({ref_req, ref_overrun, ref_en, wr_en, rd_en}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("init_en_rise", 32'(init_en), 1);
      chk("init_pins", 32'(pins), 32'(INIT_B));
      hi_cnt = 1;
      for (int i = 1; i < 20000; i++) begin
         @(negedge clk);
         hi_cnt += int'(init_en);
      end
      init_done = 1'b1;
      @(negedge clk);
      init_done = 1'b0;
      e0 = cyc;
      chk("init_span", 32'(hi_cnt), 20000);
      chk("init_en_fall", 32'(init_en), 0);
      chk("arbit_pins", 32'(pins), 32'(NOP_B));
      chk("arbit_busy", 32'(busy), 0);

      to_edge(P);
      chk("ref1_early", 32'(ref_req), 0);
      to_edge(P + 1);
      chk("ref1_rise", 32'(ref_req), 1);
      to_edge(P + 2);
      chk("ref1_grant", 32'({ref_en, ref_req, busy}), 32'(3'b101));
      chk("ref1_pins", 32'(pins), 32'(REF_B));
      to_edge(P + 5);
      wr_done = 1'b1;
      to_edge(P + 6);
      wr_done = 1'b0;
      chk("stray_done", 32'(ref_en), 1);
      to_edge(P + 9);
      ref_done = 1'b1;
      to_edge(P + 10);
      ref_done = 1'b0;
      chk("ref1_end", 32'({ref_en, busy}), 0);
      chk("ref1_nop", 32'(pins), 32'(NOP_B));

      to_edge(2 * P);
      chk("ref2_early", 32'(ref_req), 0);
      to_edge(2 * P + 1);
      chk("ref2_rise", 32'(ref_req), 1);
      to_edge(2 * P + 2);
      chk("ref2_grant", 32'(ref_en), 1);
      to_edge(2 * P + 9);
      ref_done = 1'b1;
      to_edge(2 * P + 10);
      ref_done = 1'b0;
      chk("ref2_ovr", 32'(ref_overrun), 0);
      chk("ref2_end", 32'(busy), 0);

      wr_req = 1'b1;
      rd_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         int g;
         g = 2 * P + 11 + 5 * k;
         to_edge(g);
         if (k % 2 == 0) begin
            chk("alt_wr_grant", 32'({wr_en, rd_en}), 32'(2'b10));
            chk("alt_wr_pins", 32'(pins), 32'(WR_B));
         end else begin
            chk("alt_rd_grant", 32'({wr_en, rd_en}), 32'(2'b01));
            chk("alt_rd_pins", 32'(pins), 32'(RD_B));
         end
         to_edge(g + 3);
         if (k % 2 == 0) wr_done = 1'b1;
         else            rd_done = 1'b1;
         if (k == 3) begin
            wr_req = 1'b0;
            rd_req = 1'b0;
         end
         to_edge(g + 4);
         wr_done = 1'b0;
         rd_done = 1'b0;
         chk("alt_gap_en", 32'({wr_en, rd_en}), 0);
         chk("alt_gap_pins", 32'(pins), 32'(NOP_B));
      end

      to_edge(3 * P - 10);
      wr_req = 1'b1;
      to_edge(3 * P - 9);
      chk("rw_wr_grant", 32'(wr_en), 1);
      to_edge(3 * P - 5);
      rd_req = 1'b1;
      to_edge(3 * P);
      chk("rw_ref_early", 32'(ref_req), 0);
      to_edge(3 * P + 1);
      chk("rw_ref_rise", 32'({ref_req, wr_en}), 32'(2'b11));
      wr_done = 1'b1;
      wr_req = 1'b0;
      to_edge(3 * P + 2);
      wr_done = 1'b0;
      chk("rw_arbit", 32'({wr_en, busy, ref_req}), 32'(3'b001));
      to_edge(3 * P + 3);
      chk("rw_ref_first", 32'({ref_en, rd_en}), 32'(2'b10));
      to_edge(3 * P + 10);
      ref_done = 1'b1;
      to_edge(3 * P + 11);
      ref_done = 1'b0;
      chk("rw_ref_end", 32'(ref_en), 0);
      to_edge(3 * P + 12);
      chk("rw_rd_grant", 32'(rd_en), 1);
      chk("rw_rd_pins", 32'(pins), 32'(RD_B));
      rd_done = 1'b1;
      rd_req = 1'b0;
      to_edge(3 * P + 13);
      rd_done = 1'b0;
      wr_req = 1'b1;

      to_edge(4 * P + 1);
      chk("ovr_first", 32'({ref_req, ref_overrun, wr_en}), 32'(3'b101));
      to_edge(5 * P);
      chk("ovr_pre", 32'(ref_overrun), 0);
      to_edge(5 * P + 1);
      chk("ovr_set", 32'(ref_overrun), 1);
      wr_done = 1'b1;
      wr_req = 1'b0;
      to_edge(5 * P + 2);
      wr_done = 1'b0;
      to_edge(5 * P + 3);
      chk("ovr_ref_grant", 32'({ref_en, ref_req}), 32'(2'b10));
      to_edge(5 * P + 10);
      ref_done = 1'b1;
      to_edge(5 * P + 11);
      ref_done = 1'b0;
      chk("ovr_sticky", 32'({ref_overrun, busy}), 32'(2'b10));

      rd_req = 1'b1;
      to_edge(5 * P + 13);
      chk("rst_rd_grant", 32'(rd_en), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_en", 32'({rd_en, init_en}), 0);
      chk("rst_mid_pins", 32'(pins), 32'(RST_B));
      chk("rst_mid_flags", 32'({ref_req, ref_overrun, busy}), 32'(3'b001));
      @(negedge clk);
      rst_n = 1'b1;
      rd_req = 1'b0;
      @(negedge clk);
      chk("reinit_en", 32'({init_en, rd_en}), 32'(2'b10));
      chk("reinit_pins", 32'(pins), 32'(INIT_B));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
